// File: rtl/pipe_mag_comp_pkg.sv
// Shared types and defaults for the pipelined magnitude comparator.
package pipe_mag_comp_pkg;
  localparam int DEF_N  = 8;
  localparam int DEF_CW = 16;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  typedef struct packed {
    logic gt;
    logic ls;
    logic eq;
  } cmp_t;
endpackage

// File: rtl/pipe_mag_comp_core.sv
// Combinational signed/unsigned magnitude compare; flipping the MSB maps
// two's-complement order onto unsigned order.
module mag_cmp_core
  import pipe_mag_comp_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sgn_i,
  output cmp_t         res_o
);
  logic [N-1:0] ax, bx;

  assign ax = {a_i[N-1] ^ sgn_i, a_i[N-2:0]};
  assign bx = {b_i[N-1] ^ sgn_i, b_i[N-2:0]};

  assign res_o.gt = (ax > bx);
  assign res_o.ls = (ax < bx);
  assign res_o.eq = (ax == bx);
endmodule

// File: rtl/pipe_mag_comp.sv
// One-stage valid/ready magnitude comparator. Frame statistics (max_a,
// min_a, eq_cnt and the IDLE/ACC FSM) exist only with CMP_STATS_EN defined.
module pipe_mag_comp
  import pipe_mag_comp_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          sgn,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          gt,
  output logic          ls,
  output logic          eq,
  output logic          out_last
`ifdef CMP_STATS_EN
  ,
  output logic [N-1:0]  max_a,
  output logic [N-1:0]  min_a,
  output logic [CW-1:0] eq_cnt
`endif
);
  if (N < 2 || N > 64 || CW < 1) begin : g_bad_param
    $error("pipe_mag_comp: N must be 2..64 and CW >= 1");
  end

  logic acc;
  cmp_t ab;
  logic vld_q;
  cmp_t res_q;
  logic last_q;

  assign in_ready = !vld_q || out_ready;
  assign acc      = in_valid && in_ready;

  mag_cmp_core #(.N(N)) u_ab (.a_i(a), .b_i(b), .sgn_i(sgn), .res_o(ab));

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      res_q  <= '0;
      last_q <= 1'b0;
    end else if (acc) begin
      vld_q  <= 1'b1;
      res_q  <= ab;
      last_q <= in_last;
    end else if (out_ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign gt        = res_q.gt;
  assign ls        = res_q.ls;
  assign eq        = res_q.eq;
  assign out_last  = last_q;

`ifdef CMP_STATS_EN
  state_t        state_q, state_d;
  logic [N-1:0]  max_q, max_d, min_q, min_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmp_t          amx, amn;

  mag_cmp_core #(.N(N)) u_max (.a_i(a), .b_i(max_q), .sgn_i(sgn), .res_o(amx));
  mag_cmp_core #(.N(N)) u_min (.a_i(a), .b_i(min_q), .sgn_i(sgn), .res_o(amn));

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    cnt_d   = cnt_q;
    if (acc) begin
      state_d = in_last ? IDLE : ACC;
      if (state_q == IDLE) begin
        max_d = a;
        min_d = a;
        cnt_d = CW'(ab.eq);
      end else begin
        if (amx.gt) max_d = a;
        if (amn.ls) min_d = a;
        // saturate rather than wrap
        if (ab.eq && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      max_q   <= '0;
      min_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      cnt_q   <= cnt_d;
    end
  end

  assign max_a  = max_q;
  assign min_a  = min_q;
  assign eq_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_pipe_mag_comp.sv
// Directed bench for pipe_mag_comp; stats checks compile in with CMP_STATS_EN.
module tb_pipe_mag_comp;
  localparam int N  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, sgn, in_last;
  logic [N-1:0]  a, b;
  logic          out_valid, out_ready, gt, ls, eq, out_last;
`ifdef CMP_STATS_EN
  logic [N-1:0]  max_a, min_a;
  logic [CW-1:0] eq_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_mag_comp #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .gt(gt), .ls(ls), .eq(eq), .out_last(out_last)
`ifdef CMP_STATS_EN
    , .max_a(max_a), .min_a(min_a), .eq_cnt(eq_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // present one beat, let it be accepted on the next edge, sample #1 later
  task automatic beat(input logic [N-1:0] av, input logic [N-1:0] bv,
                      input logic s, input logic l);
    a = av; b = bv; sgn = s; in_last = l; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic g, input logic l, input logic e);
    chk({tag, ".vld"}, out_valid, 1'b1);
    chk({tag, ".gle"}, {gt, ls, eq}, {g, l, e});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sgn = 1'b0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst.vld", out_valid, 1'b0);
    chk("rst.res", {gt, ls, eq, out_last}, 4'b0000);
    chk("rst.rdy", in_ready, 1'b1);
`ifdef CMP_STATS_EN
    chk("rst.stats", {max_a, min_a, eq_cnt}, '0);
`endif

    beat(8'h80, 8'h7F, 1'b0, 1'b1);
    chk_res("uns80", 1'b1, 1'b0, 1'b0);
    beat(8'h80, 8'h7F, 1'b1, 1'b1);
    chk_res("sgn80", 1'b0, 1'b1, 1'b0);
    beat(8'h3C, 8'h3C, 1'b1, 1'b1);
    chk_res("eq3c", 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("drain.vld", out_valid, 1'b0);

    // backpressure: a second beat waits while out_ready is low
    out_ready = 1'b0;
    beat(8'h10, 8'h20, 1'b0, 1'b1);
    chk_res("bp0", 1'b0, 1'b1, 1'b0);
    a = 8'h30; b = 8'h20; sgn = 1'b0; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp.rdy", in_ready, 1'b0);
      chk_res("bp.hold", 1'b0, 1'b1, 1'b0);
    end
    out_ready = 1'b1; #1;
    chk("bp.rdy1", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_res("bp.next", 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("bp.drain", out_valid, 1'b0);

    // frame {5,250,17} vs {5,0,17}
    beat(8'd5, 8'd5, 1'b0, 1'b0);
    chk("fr.b0.last", out_last, 1'b0);
    beat(8'd250, 8'd0, 1'b0, 1'b0);
    chk_res("fr.b1", 1'b1, 1'b0, 1'b0);
    beat(8'd17, 8'd17, 1'b0, 1'b1);
    chk_res("fr.b2", 1'b0, 1'b0, 1'b1);
    chk("fr.last", out_last, 1'b1);
`ifdef CMP_STATS_EN
    chk("fr.max", max_a, 8'd250);
    chk("fr.min", min_a, 8'd5);
    chk("fr.cnt", eq_cnt, 2'd2);
    @(posedge clk); #1;
    chk("fr.hold", {max_a, min_a, eq_cnt}, {8'd250, 8'd5, 2'd2});
`endif

    // saturation: five equal beats with a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      beat(8'd7, 8'd7, 1'b0, (i == 4));
`ifdef CMP_STATS_EN
      if (i >= 2) chk("sat.cnt", eq_cnt, 2'd3);
`endif
    end
    chk("sat.last", out_last, 1'b1);

    // reset mid-frame, with a beat offered in the reset cycle
    beat(8'd9, 8'd1, 1'b0, 1'b0);
    chk_res("mid.b0", 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    beat(8'd100, 8'd1, 1'b0, 1'b0);
    rst = 1'b0;
    chk("mid.vld", out_valid, 1'b0);
    chk("mid.res", {gt, ls, eq, out_last}, 4'b0000);
`ifdef CMP_STATS_EN
    chk("mid.stats", {max_a, min_a, eq_cnt}, '0);
`endif
    beat(8'd3, 8'd4, 1'b0, 1'b1);
    chk_res("fresh", 1'b0, 1'b1, 1'b0);
    chk("fresh.last", out_last, 1'b1);
`ifdef CMP_STATS_EN
    chk("fresh.max", max_a, 8'd3);
    chk("fresh.min", min_a, 8'd3);
    chk("fresh.cnt", eq_cnt, 2'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
